// File: rtl/rpn_pkg.sv
`default_nettype none
// ==========================================================================
// rpn_pkg : opcodes, error codes and FSM encoding for the RPN stack controller
// Rev 1.0
// ==========================================================================
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'b000,
    OP_POP   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_DUP   = 3'b100,
    OP_SWAP  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EXEC = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// ==========================================================================
// rpn_alu : combinational 8-bit add/subtract, y = a op b (mod 256)
// Rev 1.0
// ==========================================================================
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  op_e        op,
  output logic [7:0] y
);

  always_comb begin
    y = a + b;
    if (op == OP_SUB) y = a - b;
  end

endmodule
`default_nettype wire

// File: rtl/rpn_stack_ctrl.sv
`default_nettype none
// ==========================================================================
// rpn_stack_ctrl : RPN stack with top in a register, lower entries in RAM
// Rev 1.0
// ==========================================================================
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_data,
  output logic [7:0]    top,
  output logic [AW:0]   depth,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata
);

  localparam logic [AW:0] DEPTH_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] DEPTH_ONE  = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  top_q, top_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  nos_q, nos_d;
  logic [AW:0] depth_q, depth_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  alu_y;
  logic [AW-1:0] addr_top, addr_nos;

  op_e cmd_op_e;
  assign cmd_op_e = op_e'(cmd_op);

  // Modulo-2^AW arithmetic is exact here because depth never exceeds 2^AW.
  assign addr_top = depth_q[AW-1:0] - AW'(1);
  assign addr_nos = depth_q[AW-1:0] - AW'(2);

  rpn_alu u_alu (
    .a  (mem_rdata),
    .b  (top_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    top_d   = top_q;
    data_d  = data_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op_e;
          data_d = cmd_data;
          case (cmd_op_e)
            OP_PUSH: begin
              if (depth_q == DEPTH_FULL) begin
                err_d = 1'b1; code_d = ERR_OVER;
              end else if (depth_q == '0) begin
                top_d = cmd_data; depth_d = DEPTH_ONE;
              end else begin
                state_d = ST_WR;
              end
            end
            OP_DUP: begin
              if (depth_q == '0) begin
                err_d = 1'b1; code_d = ERR_UNDER;
              end else if (depth_q == DEPTH_FULL) begin
                err_d = 1'b1; code_d = ERR_OVER;
              end else begin
                state_d = ST_WR;
              end
            end
            OP_POP: begin
              if (depth_q == '0) begin
                err_d = 1'b1; code_d = ERR_UNDER;
              end else if (depth_q == DEPTH_ONE) begin
                top_d = 8'd0; depth_d = '0;
              end else begin
                state_d = ST_RD;
              end
            end
            OP_ADD, OP_SUB, OP_SWAP: begin
              if (depth_q < (AW+1)'(2)) begin
                err_d = 1'b1; code_d = ERR_UNDER;
              end else begin
                state_d = ST_RD;
              end
            end
            OP_CLEAR: begin
              top_d = 8'd0; depth_d = '0; err_d = 1'b0; code_d = ERR_NONE;
            end
            default: begin
              err_d = 1'b1; code_d = ERR_ILLEGAL;
            end
          endcase
        end
      end
      ST_RD: state_d = ST_EXEC;
      ST_EXEC: begin
        // SWAP keeps NOS aside so the old top can be written back in WR.
        if (op_q == OP_SWAP) begin
          nos_d   = mem_rdata;
          state_d = ST_WR;
        end else begin
          top_d   = (op_q == OP_POP) ? mem_rdata : alu_y;
          depth_d = depth_q - DEPTH_ONE;
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (op_q == OP_SWAP) begin
          top_d = nos_q;
        end else begin
          depth_d = depth_q + DEPTH_ONE;
          if (op_q == OP_PUSH) top_d = data_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      top_q   <= 8'd0;
      data_q  <= 8'd0;
      nos_q   <= 8'd0;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      top_q   <= top_d;
      data_q  <= data_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'd0;
    mem_we    = 1'b0;
    case (state_q)
      ST_RD: mem_addr = addr_nos;
      ST_WR: begin
        mem_we    = 1'b1;
        mem_wdata = top_q;
        mem_addr  = (op_q == OP_SWAP) ? addr_nos : addr_top;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign top       = top_q;
  assign depth     = depth_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
`default_nettype wire
